masked_bv8_inv_stage2_lanes: RTL and testbench

// - Multi-lane, flow-controlled successor of the 4-stage masked GF(2^8) inverse stage 2.
// - Per lane: masked theta of pow4 (1 cycle) and two HPC1 products a0*pow4, a1*pow4 (2 cycles).
// - Adds valid tracking, randomness-starvation stalls and a stall counter.
// - Sits between inverse stage 1 and stage 3 in the multi-S-box AES datapath.

---
 rtl/masked_bv8_inv_stage2_lanes.sv | 250 +++++++++++++++++++++++++
 tb/tb_masked_bv8_inv_stage2_lanes.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_bv8_inv_stage2_lanes.sv
// Multi-lane masked stage 2 of the tower-field GF(2^8) inverse: masked theta of pow4 plus
// HPC1 products a0*pow4 and a1*pow4. Optional build macro: MASKED_STAGE2_ZEROIZE_EN.
package masked_bv8_stage2_pkg;

  // Fresh random bits per lane: joint refresh, two DOM products, theta DOM product.
  function automatic int stage_2_lat4_randoms(input int d);
    return 4 * (d - 1) + 10 * ((d * (d - 1)) / 2);
  endfunction

  // Index of the unordered share pair (i, j), i < j, in a d-share DOM gadget.
  function automatic int pair_idx(input int d, input int i, input int j);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // GF(2^2) element {b1,b0} = b1*w + b0 with w^2 = w + 1.
  function automatic logic [1:0] gf22_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf22_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf22_scl_n(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  // GF(2^4) = GF(2^2)[y] / (y^2 + y + w), nibble = {high, low}.
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = gf22_mul(a[3:2], b[3:2]);
    return {hh ^ gf22_mul(a[3:2], b[1:0]) ^ gf22_mul(a[1:0], b[3:2]),
            gf22_scl_n(hh) ^ gf22_mul(a[1:0], b[1:0])};
  endfunction

endpackage

module masked_bv8_inv_stage2_lanes
  import masked_bv8_stage2_pkg::*;
#(
  parameter int NUM_SHARES  = 2,
  parameter int NUM_LANES   = 1,
  parameter int STALL_CNT_W = 16,
  localparam int LANE_RANDOM = stage_2_lat4_randoms(NUM_SHARES)
) (
  input  logic                                      in_clock,
  input  logic                                      in_reset,
  input  logic                                      in_valid,
  output logic                                      out_ready,
  input  logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] in_a0_t1,
  input  logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] in_a1_t1,
  input  logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] in_pow4_t1,
  input  logic [NUM_LANES*LANE_RANDOM-1:0]          in_random,
  input  logic                                      in_random_valid,
  output logic                                      out_theta_valid,
  output logic [NUM_LANES-1:0][NUM_SHARES-1:0][1:0] out_theta_t2,
  output logic                                      out_mul_valid,
  output logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] out_mul_a0_t3,
  output logic [NUM_LANES-1:0][NUM_SHARES-1:0][3:0] out_mul_a1_t3,
  output logic [STALL_CNT_W-1:0]                    out_stall_count
);

  localparam int NS    = NUM_SHARES;
  localparam int NL    = NUM_LANES;
  localparam int NP    = (NS * (NS - 1)) / 2;
  localparam int OFF_R = 2 * NP;
  localparam int OFF_L = 6 * NP;
  localparam int OFF_J = 10 * NP;

  logic                            accept_s;
  logic                            gate_s;
  logic [NL-1:0][NS-1:0][3:0]      a0_g_s;
  logic [NL-1:0][NS-1:0][3:0]      a1_g_s;
  logic [NL-1:0][NS-1:0][3:0]      pw_g_s;
  logic [NL*LANE_RANDOM-1:0]       rnd_g_s;

  logic                            v1_d, v1_q;
  logic                            v2_d, v2_q;
  logic [STALL_CNT_W-1:0]          stall_cnt_d, stall_cnt_q;
  logic [NL-1:0][NS-1:0][NS-1:0][1:0] th_terms_d, th_terms_q;
  logic [NL-1:0][NS-1:0][3:0]      a0_d, a0_q;
  logic [NL-1:0][NS-1:0][3:0]      a1_d, a1_q;
  logic [NL-1:0][NS-1:0][3:0]      pw_ref_d, pw_ref_q;
  logic [NL-1:0][NP-1:0][3:0]      rl_d, rl_q;
  logic [NL-1:0][NP-1:0][3:0]      rr_d, rr_q;
  logic [NL-1:0][NS-1:0][NS-1:0][3:0] m0_terms_d, m0_terms_q;
  logic [NL-1:0][NS-1:0][NS-1:0][3:0] m1_terms_d, m1_terms_q;

  logic [LANE_RANDOM-1:0]          lane_rnd_s;
  logic [NP-1:0][1:0]              th_r_s;
  logic [NS-1:0][3:0]              jr_s;
  logic [3:0]                      mz_s;
  logic [1:0]                      th_t_s;
  logic [3:0]                      p0_s, p1_s;
  logic [NL-1:0][NS-1:0][1:0]      theta_x_s;
  logic [NL-1:0][NS-1:0][3:0]      mul0_x_s, mul1_x_s;

  assign out_ready       = in_random_valid;
  assign out_theta_valid = v1_q;
  assign out_mul_valid   = v2_q;
  assign out_stall_count = stall_cnt_q;

  // Accept decision and the optional zeroization of everything entering the gadgets.
  always_comb begin
    accept_s = in_valid & in_random_valid;
`ifdef MASKED_STAGE2_ZEROIZE_EN
    gate_s = accept_s;
`else
    gate_s = 1'b1;
`endif
    a0_g_s  = gate_s ? in_a0_t1   : '0;
    a1_g_s  = gate_s ? in_a1_t1   : '0;
    pw_g_s  = gate_s ? in_pow4_t1 : '0;
    rnd_g_s = gate_s ? in_random  : '0;
  end

  // Valid pipe, saturating starvation counter and a0/a1 hold register.
  always_comb begin
    v1_d = accept_s;
    v2_d = v1_q;
    if (in_valid && !in_random_valid && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    a0_d = a0_g_s;
    a1_d = a1_g_s;
  end

  // First layer: theta DOM terms, pow4 refresh with masked zero, capture of product randomness.
  always_comb begin
    th_terms_d = '0;
    pw_ref_d   = '0;
    rl_d       = '0;
    rr_d       = '0;
    lane_rnd_s = '0;
    th_r_s     = '0;
    jr_s       = '0;
    mz_s       = 4'h0;
    th_t_s     = 2'b00;
    for (int ln = 0; ln < NL; ln++) begin
      lane_rnd_s = rnd_g_s[ln*LANE_RANDOM +: LANE_RANDOM];
      for (int k = 0; k < NP; k++) begin
        th_r_s[k]   = lane_rnd_s[2*k +: 2];
        rr_d[ln][k] = lane_rnd_s[OFF_R + 4*k +: 4];
        rl_d[ln][k] = lane_rnd_s[OFF_L + 4*k +: 4];
      end
      // jr_s[NS-1] stays zero so the ring below is a sharing of zero
      jr_s = '0;
      for (int k = 0; k < NS - 1; k++) begin
        jr_s[k] = lane_rnd_s[OFF_J + 4*k +: 4];
      end
      for (int i = 0; i < NS; i++) begin
        mz_s = jr_s[i] ^ jr_s[(i > 0) ? i - 1 : NS - 1];
        pw_ref_d[ln][i] = pw_g_s[ln][i] ^ mz_s;
      end
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < NS; j++) begin
          th_t_s = gf22_mul(pw_g_s[ln][i][3:2], pw_g_s[ln][j][1:0]);
          if (i == j) begin
            th_t_s = th_t_s ^ gf22_scl_n(gf22_sq(pw_g_s[ln][i][3:2])) ^ gf22_sq(pw_g_s[ln][i][1:0]);
          end else begin
            th_t_s = th_t_s ^ th_r_s[(i < j) ? pair_idx(NS, i, j) : pair_idx(NS, j, i)];
          end
          th_terms_d[ln][i][j] = th_t_s;
        end
      end
    end
  end

  // Second HPC1 layer: held a0/a1 meet refreshed pow4, cross terms blinded before registering.
  always_comb begin
    m0_terms_d = '0;
    m1_terms_d = '0;
    p0_s       = 4'h0;
    p1_s       = 4'h0;
    for (int ln = 0; ln < NL; ln++) begin
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < NS; j++) begin
          p0_s = gf4_mul(a0_q[ln][i], pw_ref_q[ln][j]);
          p1_s = gf4_mul(a1_q[ln][i], pw_ref_q[ln][j]);
          if (i != j) begin
            p0_s = p0_s ^ rl_q[ln][(i < j) ? pair_idx(NS, i, j) : pair_idx(NS, j, i)];
            p1_s = p1_s ^ rr_q[ln][(i < j) ? pair_idx(NS, i, j) : pair_idx(NS, j, i)];
          end else begin
            p0_s = p0_s;
            p1_s = p1_s;
          end
          m0_terms_d[ln][i][j] = p0_s;
          m1_terms_d[ln][i][j] = p1_s;
        end
      end
    end
  end

  // Output share compression of the registered DOM terms.
  always_comb begin
    theta_x_s = '0;
    mul0_x_s  = '0;
    mul1_x_s  = '0;
    for (int ln = 0; ln < NL; ln++) begin
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < NS; j++) begin
          theta_x_s[ln][i] = theta_x_s[ln][i] ^ th_terms_q[ln][i][j];
          mul0_x_s[ln][i]  = mul0_x_s[ln][i] ^ m0_terms_q[ln][i][j];
          mul1_x_s[ln][i]  = mul1_x_s[ln][i] ^ m1_terms_q[ln][i][j];
        end
      end
    end
`ifdef MASKED_STAGE2_ZEROIZE_EN
    out_theta_t2  = v1_q ? theta_x_s : '0;
    out_mul_a0_t3 = v2_q ? mul0_x_s  : '0;
    out_mul_a1_t3 = v2_q ? mul1_x_s  : '0;
`else
    out_theta_t2  = theta_x_s;
    out_mul_a0_t3 = mul0_x_s;
    out_mul_a1_t3 = mul1_x_s;
`endif
  end

  // Pipeline registers; reset drops in-flight beats and clears all gadget state.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      stall_cnt_q <= '0;
      th_terms_q  <= '0;
      a0_q        <= '0;
      a1_q        <= '0;
      pw_ref_q    <= '0;
      rl_q        <= '0;
      rr_q        <= '0;
      m0_terms_q  <= '0;
      m1_terms_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      stall_cnt_q <= stall_cnt_d;
      th_terms_q  <= th_terms_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      pw_ref_q    <= pw_ref_d;
      rl_q        <= rl_d;
      rr_q        <= rr_d;
      m0_terms_q  <= m0_terms_d;
      m1_terms_q  <= m1_terms_d;
    end
  end

endmodule

// File: tb/tb_masked_bv8_inv_stage2_lanes.sv
// Randomized self-checking bench for masked_bv8_inv_stage2_lanes (4 lanes, 2 shares, 4-bit counter);
// reference model works on unmasked values in the tower field GF((2^2)^2).
module tb_masked_bv8_inv_stage2_lanes;

  localparam int S  = 2;
  localparam int L  = 4;
  localparam int W  = 4;
  localparam int NP = S * (S - 1) / 2;
  localparam int LR = 4 * (S - 1) + 4 * NP + 4 * NP + 2 * NP;

  logic                      in_clock;
  logic                      in_reset;
  logic                      in_valid;
  logic                      out_ready;
  logic [L-1:0][S-1:0][3:0]  in_a0_t1;
  logic [L-1:0][S-1:0][3:0]  in_a1_t1;
  logic [L-1:0][S-1:0][3:0]  in_pow4_t1;
  logic [L*LR-1:0]           in_random;
  logic                      in_random_valid;
  logic                      out_theta_valid;
  logic [L-1:0][S-1:0][1:0]  out_theta_t2;
  logic                      out_mul_valid;
  logic [L-1:0][S-1:0][3:0]  out_mul_a0_t3;
  logic [L-1:0][S-1:0][3:0]  out_mul_a1_t3;
  logic [W-1:0]              out_stall_count;

  masked_bv8_inv_stage2_lanes #(
    .NUM_SHARES (S),
    .NUM_LANES  (L),
    .STALL_CNT_W(W)
  ) dut (
    .in_clock       (in_clock),
    .in_reset       (in_reset),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_a0_t1       (in_a0_t1),
    .in_a1_t1       (in_a1_t1),
    .in_pow4_t1     (in_pow4_t1),
    .in_random      (in_random),
    .in_random_valid(in_random_valid),
    .out_theta_valid(out_theta_valid),
    .out_theta_t2   (out_theta_t2),
    .out_mul_valid  (out_mul_valid),
    .out_mul_a0_t3  (out_mul_a0_t3),
    .out_mul_a1_t3  (out_mul_a1_t3),
    .out_stall_count(out_stall_count)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  typedef struct packed {
    logic [31:0]    due;
    logic [2*L-1:0] th;
    logic [4*L-1:0] m0;
    logic [4*L-1:0] m1;
  } beat_t;

  beat_t      th_q[$];
  beat_t      mul_q[$];
  int         checks  = 0;
  int         errors  = 0;
  int         edge_n  = 0;
  int         exp_cnt = 0;
  int         run     = 0;
  int         max_run = 0;
  logic [3:0] cur_a0[L];
  logic [3:0] cur_a1[L];
  logic [3:0] cur_pw[L];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // GF(4) via discrete logs: 1=w^0, 2=w^1, 3=w^2.
  function automatic logic [1:0] f4_exp(input int e);
    case (e % 3)
      0:       return 2'd1;
      1:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] f4_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd0 || b == 2'd0) return 2'd0;
    return f4_exp((int'(a) - 1) + (int'(b) - 1));
  endfunction

  // Polynomial product over GF(4), reduced with y^2 = y + w.
  function automatic logic [3:0] f16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] c2, c1, c0;
    c2 = f4_mul(a[3:2], b[3:2]);
    c1 = f4_mul(a[3:2], b[1:0]) ^ f4_mul(a[1:0], b[3:2]);
    c0 = f4_mul(a[1:0], b[1:0]);
    return {c1 ^ c2, c0 ^ f4_mul(c2, 2'd2)};
  endfunction

  // theta is the GF(16)->GF(4) norm, i.e. p^5.
  function automatic logic [3:0] f16_pow5(input logic [3:0] p);
    logic [3:0] r;
    r = 4'h1;
    for (int i = 0; i < 5; i++) r = f16_mul(r, p);
    return r;
  endfunction

  task automatic share4(input logic [3:0] v, output logic [S-1:0][3:0] sh);
    logic [3:0] acc;
    acc = v;
    for (int s = 0; s < S - 1; s++) begin
      sh[s] = 4'($urandom_range(0, 15));
      acc   = acc ^ sh[s];
    end
    sh[S-1] = acc;
  endtask

  task automatic load(input int l, input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] pw);
    cur_a0[l] = a0;
    cur_a1[l] = a1;
    cur_pw[l] = pw;
    share4(a0, in_a0_t1[l]);
    share4(a1, in_a1_t1[l]);
    share4(pw, in_pow4_t1[l]);
  endtask

  task automatic drive(input logic v, input logic rv, input logic fresh);
    in_valid        = v;
    in_random_valid = rv;
    if (fresh) begin
      for (int l = 0; l < L; l++)
        load(l, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < L * LR; i++) in_random[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    logic           acc;
    logic           exp_tv, exp_mv;
    logic [3:0]     p5;
    logic [1:0]     g2;
    logic [3:0]     g4a, g4b;
    logic [2*L-1:0] got_th;
    logic [4*L-1:0] got_m0, got_m1;
    beat_t          b, e;
    acc = in_valid & in_random_valid;
    @(posedge in_clock);
    edge_n++;
    if (in_reset) begin
      th_q.delete();
      mul_q.delete();
      exp_cnt = 0;
    end else begin
      if (in_valid && !in_random_valid && exp_cnt < (1 << W) - 1) exp_cnt++;
      if (acc) begin
        for (int l = 0; l < L; l++) begin
          p5 = f16_pow5(cur_pw[l]);
          b.th[2*l +: 2] = p5[1:0];
          b.m0[4*l +: 4] = f16_mul(cur_a0[l], cur_pw[l]);
          b.m1[4*l +: 4] = f16_mul(cur_a1[l], cur_pw[l]);
        end
        b.due = 32'(edge_n);
        th_q.push_back(b);
        b.due = 32'(edge_n + 1);
        mul_q.push_back(b);
      end
    end
    #1;
    for (int l = 0; l < L; l++) begin
      g2 = 2'b00; g4a = 4'h0; g4b = 4'h0;
      for (int s = 0; s < S; s++) begin
        g2  = g2 ^ out_theta_t2[l][s];
        g4a = g4a ^ out_mul_a0_t3[l][s];
        g4b = g4b ^ out_mul_a1_t3[l][s];
      end
      got_th[2*l +: 2] = g2;
      got_m0[4*l +: 4] = g4a;
      got_m1[4*l +: 4] = g4b;
    end
    check_eq("ready", 64'(out_ready), 64'(in_random_valid));
    check_eq("stall_count", 64'(out_stall_count), 64'(exp_cnt));
    exp_tv = (th_q.size() > 0) && (th_q[0].due == 32'(edge_n));
    check_eq("theta_valid", 64'(out_theta_valid), 64'(exp_tv));
    if (exp_tv) begin
      e = th_q.pop_front();
      check_eq("theta", 64'(got_th), 64'(e.th));
    end
    exp_mv = (mul_q.size() > 0) && (mul_q[0].due == 32'(edge_n));
    check_eq("mul_valid", 64'(out_mul_valid), 64'(exp_mv));
    if (exp_mv) begin
      e = mul_q.pop_front();
      check_eq("mul_a0", 64'(got_m0), 64'(e.m0));
      check_eq("mul_a1", 64'(got_m1), 64'(e.m1));
    end
`ifdef MASKED_STAGE2_ZEROIZE_EN
    if (!out_theta_valid) check_eq("zero_theta", 64'(out_theta_t2), 64'd0);
    if (!out_mul_valid) begin
      check_eq("zero_mul_a0", 64'(out_mul_a0_t3), 64'd0);
      check_eq("zero_mul_a1", 64'(out_mul_a1_t3), 64'd0);
    end
`endif
    if (out_mul_valid) run++;
    else run = 0;
    if (run > max_run) max_run = run;
  endtask

  initial begin
    in_reset        = 1'b1;
    in_valid        = 1'b0;
    in_random_valid = 1'b1;
    in_a0_t1        = '0;
    in_a1_t1        = '0;
    in_pow4_t1      = '0;
    in_random       = '0;
    for (int l = 0; l < L; l++) begin
      cur_a0[l] = 4'h0; cur_a1[l] = 4'h0; cur_pw[l] = 4'h0;
    end
    // reset, with out_ready following in_random_valid throughout
    step();
    drive(1'b1, 1'b0, 1'b1);
    step();
    check_eq("rst_theta_shares", 64'(out_theta_t2), 64'd0);
    check_eq("rst_mul_a0_shares", 64'(out_mul_a0_t3), 64'd0);
    check_eq("rst_mul_a1_shares", 64'(out_mul_a1_t3), 64'd0);
    in_reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    step();

    // directed beat: a0=3, a1=5, pow4=7 in lane 0
    drive(1'b1, 1'b1, 1'b1);
    load(0, 4'h3, 4'h5, 4'h7);
    step();
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) step();

    // 100 back-to-back beats
    max_run = 0;
    repeat (100) begin
      drive(1'b1, 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) step();
    check_eq("b2b_run", 64'(max_run), 64'd100);

    // three starved cycles, data held, then accept
    drive(1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0);
    repeat (2) step();
    check_eq("stall3", 64'(out_stall_count), 64'd3);
    drive(1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) step();

    // saturation of the 4-bit counter
    drive(1'b1, 1'b0, 1'b1);
    repeat (20) step();
    check_eq("stall_sat", 64'(out_stall_count), 64'hF);

    // reset one cycle after an accept discards the beat
    drive(1'b1, 1'b1, 1'b1);
    step();
    in_reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    step();
    check_eq("rst_mid_theta_valid", 64'(out_theta_valid), 64'd0);
    check_eq("rst_mid_mul_valid", 64'(out_mul_valid), 64'd0);
    in_reset = 1'b0;
    repeat (3) step();

    // randomized mix of accepts, stalls, idles and occasional resets
    repeat (400) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b1);
      in_reset = ($urandom_range(0, 49) == 0);
      step();
    end
    in_reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) step();

`ifdef MASKED_STAGE2_ZEROIZE_EN
    // idle with toggling randomness: shares must stay zero
    repeat (10) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
